// File: rtl/color_scan_ctrl_pkg.sv
// Shared codes for the colour scan sequencer: colour results, filter selects, FSM states.
package color_pkg;
   localparam logic [2:0] COLOR_RED   = 3'b100;
   localparam logic [2:0] COLOR_GRN   = 3'b010;
   localparam logic [2:0] COLOR_BLU   = 3'b001;
   localparam logic [2:0] COLOR_DARK  = 3'b000;
   localparam logic [2:0] COLOR_WHITE = 3'b111;

   // {s2, s3} photodiode filter selects
   localparam logic [1:0] FS_R = 2'b00;
   localparam logic [1:0] FS_G = 2'b11;
   localparam logic [1:0] FS_B = 2'b01;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETTLE, ST_GATE, ST_LATCH, ST_CLASSIFY, ST_DONE
   } state_t;

   function automatic logic [1:0] fs_code(input logic [1:0] ch);
      case (ch)
         CH_G:    fs_code = FS_G;
         CH_B:    fs_code = FS_B;
         default: fs_code = FS_R;
      endcase
   endfunction
endpackage

// File: rtl/color_scan_ctrl_if.sv
// Scan handshake plus the sensor/counter hookup of the colour scan sequencer.
interface color_scan_ctrl_if #(parameter int CW = 16);
   logic          req;
   logic          cont;
   logic          busy;
   logic          done;
   logic [2:0]    color;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] g_cnt;
   logic [CW-1:0] b_cnt;
   logic          s2;
   logic          s3;
   logic          cnt_clr;
   logic          cnt_en;
   logic [CW-1:0] cnt_val;

   modport slave (
      input  req, cont, cnt_val,
      output busy, done, color, r_cnt, g_cnt, b_cnt, s2, s3, cnt_clr, cnt_en
   );
   modport master (
      output req, cont, cnt_val,
      input  busy, done, color, r_cnt, g_cnt, b_cnt, s2, s3, cnt_clr, cnt_en
   );
endinterface

// File: rtl/color_scan_ctrl_classify.sv
// Dominant-colour decision over three channel counts (pure combinational).
module color_classify
   import color_pkg::*;
#(
   parameter int CW          = 16,
   parameter int DARK_MAX    = 16,
   parameter int WHITE_DELTA = 8
) (
   input  logic [CW-1:0] r,
   input  logic [CW-1:0] g,
   input  logic [CW-1:0] b,
   output logic [2:0]    color
);
   logic [CW-1:0] mx;
   logic [CW-1:0] mn;

   always_comb begin
      mx = r;
      mn = r;
      if (g > mx) mx = g;
      if (b > mx) mx = b;
      if (g < mn) mn = g;
      if (b < mn) mn = b;

      // mx >= mn, so the difference fits in CW bits
      if (mx <= CW'(DARK_MAX))                color = COLOR_DARK;
      else if ((mx - mn) <= CW'(WHITE_DELTA)) color = COLOR_WHITE;
      else if (r >= g && r >= b)              color = COLOR_RED;
      else if (g >= b)                        color = COLOR_GRN;
      else                                    color = COLOR_BLU;
   end
endmodule

// File: rtl/color_scan_ctrl.sv
// Colour sensor scan sequencer: settle/gate/latch per R,G,B channel, then classify.
module color_scan_ctrl
   import color_pkg::*;
#(
   parameter int CW          = 16,
   parameter int SETTLE_CYC  = 5000,
   parameter int GATE_CYC    = 50000,
   parameter int DARK_MAX    = 16,
   parameter int WHITE_DELTA = 8
) (
   input logic              clk,
   input logic              reset,
   color_scan_ctrl_if.slave bus
);
   localparam int TMAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [1:0]    ch, ch_n;
   logic [CW-1:0] r_q, g_q, b_q;
   logic [2:0]    color_q, cls_color;

   color_classify #(
      .CW(CW), .DARK_MAX(DARK_MAX), .WHITE_DELTA(WHITE_DELTA)
   ) u_cls (
      .r(r_q), .g(g_q), .b(b_q), .color(cls_color)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         timer   <= '0;
         ch      <= CH_R;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         color_q <= COLOR_DARK;
      end else begin
         state <= state_n;
         timer <= timer_n;
         ch    <= ch_n;
         if (state == ST_LATCH) begin
            case (ch)
               CH_R:    r_q <= bus.cnt_val;
               CH_G:    g_q <= bus.cnt_val;
               default: b_q <= bus.cnt_val;
            endcase
         end
         // registered here so color is already valid in the DONE cycle
         if (state == ST_CLASSIFY) color_q <= cls_color;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      ch_n    = ch;
      case (state)
         ST_IDLE: if (bus.req) begin
            state_n = ST_SETTLE;
            timer_n = '0;
            ch_n    = CH_R;
         end
         ST_SETTLE: if (timer == TW'(SETTLE_CYC - 1)) begin
            state_n = ST_GATE;
            timer_n = '0;
         end else timer_n = timer + TW'(1);
         ST_GATE: if (timer == TW'(GATE_CYC - 1)) begin
            state_n = ST_LATCH;
            timer_n = '0;
         end else timer_n = timer + TW'(1);
         ST_LATCH: if (ch == CH_B) state_n = ST_CLASSIFY;
         else begin
            state_n = ST_SETTLE;
            ch_n    = ch + 2'd1;
            timer_n = '0;
         end
         ST_CLASSIFY: state_n = ST_DONE;
         ST_DONE: if (bus.cont) begin
            state_n = ST_SETTLE;
            ch_n    = CH_R;
            timer_n = '0;
         end else state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.busy          = (state != ST_IDLE);
   assign bus.done          = (state == ST_DONE);
   assign bus.cnt_en        = (state == ST_GATE);
   assign bus.cnt_clr       = (state == ST_SETTLE) && (timer == TW'(SETTLE_CYC - 1));
   assign {bus.s2, bus.s3}  = (state == ST_IDLE) ? FS_R : fs_code(ch);
   assign bus.color         = color_q;
   assign bus.r_cnt         = r_q;
   assign bus.g_cnt         = g_q;
   assign bus.b_cnt         = b_q;
endmodule

// File: tb/tb_color_scan_ctrl.sv
// Directed bench for color_scan_ctrl with a constant-per-channel counter model.
module tb_color_scan_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [15:0] rv, gv, bv;
   int n_chk = 0;
   int n_fail = 0;
   int n_done = 0, n_idle = 0, n_clr = 0;
   int en_r = 0, en_g = 0, en_b = 0;
   logic [5:0] clr_seq = '0;

   color_scan_ctrl_if #(.CW(16)) bus ();

   color_scan_ctrl #(
      .CW(16), .SETTLE_CYC(4), .GATE_CYC(10), .DARK_MAX(16), .WHITE_DELTA(8)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      case ({bus.s2, bus.s3})
         2'b00:   bus.cnt_val = rv;
         2'b11:   bus.cnt_val = gv;
         default: bus.cnt_val = bv;
      endcase
   end

   always @(negedge clk) begin
      if (bus.done) n_done++;
      if (!bus.busy) n_idle++;
      if (bus.cnt_clr) begin
         n_clr++;
         clr_seq = {clr_seq[3:0], bus.s2, bus.s3};
      end
      if (bus.cnt_en) begin
         case ({bus.s2, bus.s3})
            2'b00:   en_r++;
            2'b11:   en_g++;
            default: en_b++;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge while idle; returns at the negedge of the done cycle
   task automatic scan(output int lat);
      bus.req = 1'b1;
      lat = 0;
      @(negedge clk);
      bus.req = 1'b0;
      lat = 1;
      while (!bus.done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.done && lat < 200);
   endtask

   task automatic wait_g_gate(output int lat);
      lat = 0;
      while (!(bus.cnt_en && {bus.s2, bus.s3} == 2'b11) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, w, d0, i0, c0, er0, eg0, eb0;
      reset = 1'b1;
      bus.req = 1'b0;
      bus.cont = 1'b0;
      rv = 16'd200; gv = 16'd50; bv = 16'd40;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_en", bus.cnt_en, 0);
      chk("rst_clr", bus.cnt_clr, 0);
      chk("rst_s2s3", {bus.s2, bus.s3}, 0);
      chk("rst_color", bus.color, 0);
      chk("rst_rcnt", bus.r_cnt, 0);
      reset = 1'b0;
      @(negedge clk);

      // scan 1: red dominant
      #1 c0 = n_clr;
      scan(lat);
      chk("s1_latency", lat, 47);
      chk("s1_color", bus.color, 3'b100);
      chk("s1_rcnt", bus.r_cnt, 200);
      chk("s1_gcnt", bus.g_cnt, 50);
      chk("s1_bcnt", bus.b_cnt, 40);
      chk("s1_busy_done", bus.busy, 1);
      #1;
      chk("s1_fs_seq", clr_seq, 6'b00_11_01);
      chk("s1_clr_count", n_clr - c0, 3);
      @(negedge clk);
      chk("s1_busy_after", bus.busy, 0);
      chk("s1_done_pulse", bus.done, 0);
      repeat (5) @(negedge clk);
      chk("s1_color_hold", bus.color, 3'b100);

      // scan 2: R/G tie resolves to red
      rv = 16'd180; gv = 16'd180; bv = 16'd20;
      scan(lat);
      chk("s2_latency", lat, 47);
      chk("s2_color_tie", bus.color, 3'b100);
      @(negedge clk);

      // scan 3: dark
      rv = 16'd10; gv = 16'd12; bv = 16'd9;
      scan(lat);
      chk("s3_color_dark", bus.color, 3'b000);
      chk("s3_gcnt", bus.g_cnt, 12);
      @(negedge clk);

      // scan 4: white, gate/clear accounting per channel
      rv = 16'd100; gv = 16'd105; bv = 16'd98;
      #1 begin c0 = n_clr; er0 = en_r; eg0 = en_g; eb0 = en_b; end
      @(negedge clk);
      scan(lat);
      chk("s4_color_white", bus.color, 3'b111);
      #1;
      chk("s4_clr_count", n_clr - c0, 3);
      chk("s4_en_r", en_r - er0, 10);
      chk("s4_en_g", en_g - eg0, 10);
      chk("s4_en_b", en_b - eb0, 10);
      @(negedge clk);

      // continuous mode with blue dominant
      rv = 16'd20; gv = 16'd40; bv = 16'd90;
      bus.cont = 1'b1;
      scan(lat);
      chk("c_latency0", lat, 47);
      chk("c_color", bus.color, 3'b001);
      #1 i0 = n_idle;
      wait_done(lat);
      chk("c_latency1", lat, 47);
      wait_done(lat);
      chk("c_latency2", lat, 47);
      #1;
      chk("c_busy_held", n_idle - i0, 0);
      repeat (10) @(negedge clk);
      bus.cont = 1'b0;
      wait_done(lat);
      chk("c_last_latency", lat, 37);
      @(negedge clk);
      chk("c_busy_drop", bus.busy, 0);
      chk("c_s2s3_idle", {bus.s2, bus.s3}, 0);

      // req re-pulsed during G gate is ignored
      rv = 16'd30; gv = 16'd200; bv = 16'd10;
      #1 d0 = n_done;
      @(negedge clk);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      wait_g_gate(w);
      chk("rp_reach_ggate", (w < 200), 1);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      wait_done(lat);
      chk("rp_color", bus.color, 3'b010);
      repeat (100) @(negedge clk);
      #1;
      chk("rp_done_count", n_done - d0, 1);
      chk("rp_idle", bus.busy, 0);

      // reset in G gate aborts
      rv = 16'd200; gv = 16'd50; bv = 16'd40;
      @(negedge clk);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      wait_g_gate(w);
      chk("ra_reach_ggate", (w < 200), 1);
      #1 d0 = n_done;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ra_busy", bus.busy, 0);
      chk("ra_en", bus.cnt_en, 0);
      chk("ra_s2s3", {bus.s2, bus.s3}, 0);
      chk("ra_color", bus.color, 0);
      chk("ra_rcnt", bus.r_cnt, 0);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      chk("ra_no_done", n_done - d0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
